// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result handshake bundle for serial_adder_ctrl (sub only with SERIAL_ADD_SUB_EN)
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, LSB first, one bit per clock; SERIAL_ADD_SUB_EN adds subtract
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             last_bit;

    // The single shared full-adder cell
    always_comb begin
        s_bit = a_sr[0] ^ b_sr[0] ^ carry;
        c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // Subtract is a + ~b + 1; cout then reads as "no borrow"
    always_comb begin
        b_load = bus.b;
        c_load = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
        if (bus.sub) begin
            b_load = ~bus.b;
            c_load = 1'b1;
        end
`endif
    end

    assign last_bit = (count == LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= b_load;
                        carry <= c_load;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {s_bit, res_sr[WIDTH-1:1]};
                    carry  <= c_nxt;
                    if (!last_bit) count <= count + 1'b1;
                    // Publish the final bit together with the rest so sum never shows a partial result
                    if (last_bit) begin
                        sum_r  <= {s_bit, res_sr[WIDTH-1:1]};
                        cout_r <= c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [W-1:0] last_sum;
    logic         last_cout;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_ops(input logic [W-1:0] ai, input logic [W-1:0] bi,
                             input logic ci, input logic si);
        bus.a   = ai;
        bus.b   = bi;
        bus.cin = ci;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = si;
`else
        if (si) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        if (bus.sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=00", bus.sum); end
        if (bus.cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
        rst = 1'b0;
        last_sum = '0;
        last_cout = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic ci, input logic si,
                         input logic [W-1:0] es, input logic ec);
        int   n;
        logic held_ok;
        bus.start = 1'b1;
        drive_ops(ai, bi, ci, si);
        @(negedge clk);
        bus.start = 1'b0;
        drive_ops(~ai, ai ^ bi, ~ci, 1'b0);
        n = 0;
        held_ok = 1'b1;
        while (!bus.done && n < 40) begin
            if (bus.sum !== last_sum || bus.cout !== last_cout || bus.busy !== 1'b1) held_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        checks += 5;
        if (n !== W) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, n, W); end
        if (!held_ok) begin failures++; $display("FAIL %s_hold_during_run got=0 exp=1", name); end
        if (bus.sum !== es) begin failures++; $display("FAIL %s_sum got=%h exp=%h", name, bus.sum, es); end
        if (bus.cout !== ec) begin failures++; $display("FAIL %s_cout got=%b exp=%b", name, bus.cout, ec); end
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL %s_busy_in_done got=%b exp=1", name, bus.busy); end
        @(negedge clk);
        checks += 3;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0", name, bus.done); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s_idle_busy got=%b exp=0", name, bus.busy); end
        if (bus.sum !== es || bus.cout !== ec) begin
            failures++; $display("FAIL %s_idle_hold got=%b/%h exp=%b/%h", name, bus.cout, bus.sum, ec, es);
        end
        last_sum = es;
        last_cout = ec;
    endtask

    task automatic test_add;
        do_op("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    endtask

    task automatic test_start_ignored;
        int n_busy;
        int n_done;
        bus.start = 1'b1;
        drive_ops(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        n_busy = 0;
        n_done = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                bus.start = 1'b1;
                drive_ops(8'h01, 8'h01, 1'b0, 1'b0);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) n_busy++;
            if (bus.done) begin
                n_done++;
                checks++;
                if (bus.sum !== 8'h46 || bus.cout !== 1'b0) begin
                    failures++; $display("FAIL ignore_result got=%b/%h exp=0/46", bus.cout, bus.sum);
                end
            end
            @(negedge clk);
        end
        checks += 3;
        if (n_busy !== W + 1) begin failures++; $display("FAIL ignore_busy_cycles got=%0d exp=%0d", n_busy, W + 1); end
        if (n_done !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
        if (bus.sum !== 8'h46) begin failures++; $display("FAIL ignore_sum_hold got=%h exp=46", bus.sum); end
        last_sum = 8'h46;
        last_cout = 1'b0;
    endtask

    task automatic test_abort;
        int n_done;
        bus.start = 1'b1;
        drive_ops(8'hAA, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        if (bus.sum !== '0) begin failures++; $display("FAIL abort_sum got=%h exp=00", bus.sum); end
        if (bus.cout !== 1'b0) begin failures++; $display("FAIL abort_cout got=%b exp=0", bus.cout); end
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        checks++;
        if (n_done !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        last_sum = '0;
        last_cout = 1'b0;
        do_op("after_abort", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub;
        do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        do_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
        do_op("sub0_add", 8'h20, 8'h22, 1'b1, 1'b0, 8'h43, 1'b0);
    endtask
`endif

    task automatic test_back_to_back;
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic         tc [4];
        logic [W:0]   gold;
        int   k;
        int   cyc;
        int   last_done;
        logic prev_done;
        ta[0] = 8'h80; tb[0] = 8'h80; tc[0] = 1'b0;
        ta[1] = 8'h7F; tb[1] = 8'h01; tc[1] = 1'b1;
        ta[2] = 8'h00; tb[2] = 8'h00; tc[2] = 1'b1;
        ta[3] = 8'hC3; tb[3] = 8'h3C; tc[3] = 1'b0;
        k = 0;
        cyc = 0;
        last_done = -1;
        prev_done = 1'b0;
        bus.start = 1'b1;
        drive_ops(ta[0], tb[0], tc[0], 1'b0);
        while (k < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                gold = {1'b0, ta[k]} + {1'b0, tb[k]} + {{W{1'b0}}, tc[k]};
                checks += 2;
                if (bus.sum !== gold[W-1:0] || bus.cout !== gold[W]) begin
                    failures++; $display("FAIL b2b_result_%0d got=%b/%h exp=%b/%h", k, bus.cout, bus.sum, gold[W], gold[W-1:0]);
                end
                if (prev_done) begin failures++; $display("FAIL b2b_done_width_%0d got=2 exp=1", k); end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done !== W + 2) begin
                        failures++; $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", k, cyc - last_done, W + 2);
                    end
                end
                last_done = cyc;
                k++;
                if (k < 4) drive_ops(ta[k], tb[k], tc[k], 1'b0);
                else bus.start = 1'b0;
            end
            prev_done = bus.done;
        end
        bus.start = 1'b0;
        checks++;
        if (k !== 4) begin failures++; $display("FAIL b2b_timeout got=%0d exp=4", k); end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_add();
        test_start_ignored();
        test_abort();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
